// File: rtl/adc_unpack_pkg.sv
// Shared types and constants for the ADC sample unpacker: FSM states,
// word geometry and the reserved-bit mask helper.
package adc_unpack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPT,
    ST_EMIT,
    ST_FIN
  } state_e;

  localparam int WORD_W           = 32;
  localparam int BYTES_PER_WORD   = 4;
  localparam int SAMPLES_PER_WORD = 3;

  // Bits of the 32-bit word above the packed samples.
  function automatic logic [WORD_W-1:0] rsvd_mask(input int sample_w);
    logic [WORD_W-1:0] m;
    m = '1;
    for (int i = 0; i < WORD_W; i++) begin
      if (i < SAMPLES_PER_WORD * sample_w) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/adc_word_assembler.sv
// Collects four FIFO bytes, LSB first, into one 32-bit word; word_full_o
// flags the load that completes the word.
module adc_word_assembler
  import adc_unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;

  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      byte_idx_d = '0;
    end else if (load_i) begin
      word_d[8*byte_idx_q +: 8] = byte_i;
      byte_idx_d                = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = load_i && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/adc_sample_unpacker.sv
// Drives the FIFO byte-read handshake and emits three SAMPLE_W samples per word
// on a valid/ready stream. ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN adds sticky rsvd_err.
module adc_sample_unpacker
  import adc_unpack_pkg::*;
#(
  parameter int SAMPLE_W = 10,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    req_samples,
  output logic                fifo_rd_ce,
  input  logic [7:0]          fifo_rd_data,
  input  logic                fifo_empty,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    samples_out
`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
  ,
  output logic                rsvd_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  samples_out_q, samples_out_d;
  logic [1:0]        lane_q, lane_d;
  logic              asm_clear, asm_load, word_full;
  logic [WORD_W-1:0] word;

  adc_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (asm_clear),
    .load_i     (asm_load),
    .byte_i     (fifo_rd_data),
    .word_o     (word),
    .word_full_o(word_full)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    samples_out_d = samples_out_q;
    lane_d        = lane_q;
    asm_clear     = 1'b0;
    asm_load      = 1'b0;
    fifo_rd_ce    = 1'b0;
    sample_valid  = 1'b0;
    sample_data   = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_d         = req_samples;
          samples_out_d = '0;
          asm_clear     = 1'b1;
          state_d       = (req_samples == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The strobe is masked during reset so an aborted readout never pops a byte.
        if (!fifo_empty) begin
          fifo_rd_ce = !rst;
          state_d    = ST_CAPT;
        end
      end
      ST_CAPT: begin
        asm_load = 1'b1;
        if (word_full) begin
          lane_d  = '0;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EMIT: begin
        sample_valid = 1'b1;
        sample_data  = word[lane_q*SAMPLE_W +: SAMPLE_W];
        if (sample_ready) begin
          samples_out_d = samples_out_q + CNT_ONE;
          lane_d        = lane_q + 2'd1;
          if (samples_out_d == cnt_q) begin
            state_d = ST_FIN;
          end else if (lane_q == 2'(SAMPLES_PER_WORD - 1)) begin
            asm_clear = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      samples_out_q <= '0;
      lane_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      samples_out_q <= samples_out_d;
      lane_q        <= lane_d;
    end
  end

  assign samples_out = samples_out_q;

`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
  localparam logic [WORD_W-1:0] RSVD_MASK = rsvd_mask(SAMPLE_W);

  logic              rsvd_err_q, rsvd_err_d;
  logic [WORD_W-1:0] word_done;

  // The top byte is still on the FIFO bus in the completing CAPT cycle.
  assign word_done = {fifo_rd_data, word[23:0]};

  always_comb begin
    rsvd_err_d = rsvd_err_q;
    if (state_q == ST_IDLE && start) begin
      rsvd_err_d = 1'b0;
    end else if (word_full && ((word_done & RSVD_MASK) != '0)) begin
      rsvd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsvd_err_q <= 1'b0;
    else     rsvd_err_q <= rsvd_err_d;
  end

  assign rsvd_err = rsvd_err_q;
`endif

endmodule

// File: tb/tb_adc_sample_unpacker.sv
// Self-checking bench for adc_sample_unpacker: byte FIFO model, sample scoreboard
// derived from the packing rule, directed and randomized readouts.
module tb_adc_sample_unpacker;
  localparam int SAMPLE_W = 10;
  localparam int CNT_W    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [CNT_W-1:0]    req_samples = '0;
  logic                fifo_rd_ce;
  logic [7:0]          fifo_rd_data = '0;
  logic                fifo_empty = 1'b1;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready = 1'b0;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    samples_out;
`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
  logic                rsvd_err;
`endif

  always #5 clk = ~clk;

  adc_sample_unpacker #(.SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .req_samples (req_samples),
    .fifo_rd_ce  (fifo_rd_ce),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .done        (done),
    .samples_out (samples_out)
`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
    ,
    .rsvd_err    (rsvd_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fifo_q[$];
  int          exp_q[$];
  logic [31:0] words_q[$];
  logic [7:0]  stash_q[$];

  int strobes = 0, accepted = 0, done_cnt = 0;
  int d0 = 0, s0 = 0, a0 = 0;
  bit pend = 1'b0;
  logic [7:0] pend_byte = '0;
  int ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
  bit hold_chk = 1'b0;
  logic [SAMPLE_W-1:0] held_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input side: FIFO byte appears the cycle after its strobe; garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (pend) begin
      fifo_rd_data = pend_byte;
      pend = 1'b0;
    end else begin
      fifo_rd_data = 8'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      2:       sample_ready = ~sample_ready;
      default: sample_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (fifo_rd_ce) begin
        strobes++;
        if (fifo_empty) chk("strobe_while_empty", 1, 0);
        if (fifo_q.size() > 0) pend_byte = fifo_q.pop_front();
        pend = 1'b1;
      end
      if (hold_chk) begin
        chk("hold_valid", sample_valid, 1);
        chk("hold_data", sample_data, held_data);
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) chk("extra_sample", 1, 0);
        else chk("sample", sample_data, exp_q.pop_front());
        accepted++;
      end
      hold_chk  = sample_valid && !sample_ready;
      held_data = sample_data;
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference: bytes LSB first per word; sample n is word[n/3] bits [10*(n%3) +: 10].
  task automatic prepare(input int nexp);
    fifo_q.delete();
    exp_q.delete();
    foreach (words_q[i])
      for (int b = 0; b < 4; b++) fifo_q.push_back(8'((words_q[i] >> (8 * b)) & 32'hFF));
    for (int n = 0; n < nexp; n++)
      exp_q.push_back(int'((words_q[n / 3] >> (SAMPLE_W * (n % 3))) & ((32'd1 << SAMPLE_W) - 1)));
  endtask

  task automatic start_run(input logic [CNT_W-1:0] req);
    d0 = done_cnt;
    s0 = strobes;
    a0 = accepted;
    req_samples = req;
    start = 1'b1;
    tick();
    start = 1'b0;
    req_samples = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", (done_cnt != d0), 1);
  endtask

  task automatic finish_run(input int req);
    chk("done_pulses", done_cnt - d0, 1);
    chk("samples_out", samples_out, req);
    chk("strobes", strobes - s0, 4 * ((req + 2) / 3));
    chk("accepted", accepted - a0, req);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_ce"}, fifo_rd_ce, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_data"}, sample_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, samples_out, 0);
  endtask

  initial begin
    int n;
    int req;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
    chk("reset_rsvd", rsvd_err, 0);
`endif
    tick();

    // One word, full readout, ready held high.
    ready_mode = 1;
    words_q = '{32'h0CA324C8};
    prepare(3);
    start_run(3);
    wait_done(100);
    finish_run(3);

    // Same word, early stop: remaining lane discarded, no fifth fetch.
    prepare(2);
    start_run(2);
    wait_done(100);
    finish_run(2);
    tick(5);
    chk("no_fifth_fetch", strobes - s0, 4);

    // Zero-length request goes straight to done.
    start_run(0);
    wait_done(10);
    finish_run(0);

    // Two words with toggling ready; a start while busy must be ignored.
    ready_mode = 2;
    words_q = '{32'h0CA324C8, (32'd701 << 20) | (32'd700 << 10) | 32'd999};
    prepare(6);
    start_run(6);
    tick(3);
    req_samples = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    finish_run(6);

    // FIFO runs dry after the first byte; partial word must be held.
    ready_mode = 1;
    words_q = '{32'h0CA324C8};
    prepare(3);
    stash_q = fifo_q[1:3];
    fifo_q = fifo_q[0:0];
    start_run(3);
    tick(12);
    chk("stall_strobes", strobes - s0, 1);
    chk("stall_busy", busy, 1);
    foreach (stash_q[i]) fifo_q.push_back(stash_q[i]);
    wait_done(100);
    finish_run(3);

    // Reset during FETCH with data available: no strobe in or after the reset cycle.
    words_q = '{32'h0CA324C8};
    prepare(3);
    start_run(3);
    rst = 1'b1;
    @(negedge clk);
    chk("rdce_rst_cycle", fifo_rd_ce, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rdce_after_rst", fifo_rd_ce, 0);
    chk("busy_after_rst", busy, 0);
    tick();

    // Reset while presenting lane 1.
    ready_mode = 0;
    words_q = '{32'h0CA324C8};
    prepare(3);
    start_run(3);
    n = 0;
    while (!sample_valid && n < 50) begin
      tick();
      n++;
    end
    chk("reach_emit", sample_valid, 1);
    ready_mode = 1;
    tick();
    ready_mode = 0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("lane1_accepted", accepted - a0, 1);
    chk("lane1_data", sample_data, 201);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("emit_rst");
    exp_q.delete();
    fifo_q.delete();
    tick();

    // Fresh readout after the abort decodes from byte 0.
    ready_mode = 1;
    words_q = '{$urandom};
    prepare(3);
    start_run(3);
    wait_done(100);
    finish_run(3);

    // Maximum count: must keep going past one word and stall on an empty FIFO.
    words_q = '{32'h0CA324C8};
    prepare(3);
    start_run('1);
    tick(30);
    chk("max_cnt_samples", samples_out, 3);
    chk("max_cnt_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Randomized readouts with random backpressure.
    ready_mode = 3;
    for (int it = 0; it < 10; it++) begin
      words_q.delete();
      for (int w = 0; w < $urandom_range(1, 3); w++) words_q.push_back($urandom);
      req = $urandom_range(1, 3 * words_q.size());
      prepare(req);
      start_run(req);
      wait_done(500);
      finish_run(req);
      tick($urandom_range(0, 3));
    end

`ifdef ADC_SAMPLE_UNPACKER_RSVD_CHECK_EN
    ready_mode = 1;
    words_q = '{32'hCCA324C8};
    prepare(3);
    start_run(3);
    wait_done(100);
    finish_run(3);
    chk("rsvd_set", rsvd_err, 1);
    words_q = '{32'h0CA324C8};
    prepare(1);
    start_run(1);
    chk("rsvd_clr", rsvd_err, 0);
    wait_done(100);
    finish_run(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
